// File: rtl/seg_disp_arbiter_if.sv
// Requester-side request/data bundle and arbiter-side grant/display outputs for seg_disp_arbiter.
// master = requesters + display consumer, slave = the arbiter itself.
interface seg_disp_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req;
  logic [32*N_REQ-1:0] req_data;
  logic [8*N_REQ-1:0]  req_valid;
  logic [N_REQ-1:0]    grant;
  logic                busy;
  logic                switch_pulse;
  logic [31:0]         output_data;
  logic [7:0]          output_valid;

  modport master (
    output req, req_data, req_valid,
    input  grant, busy, switch_pulse, output_data, output_valid
  );

  modport slave (
    input  req, req_data, req_valid,
    output grant, busy, switch_pulse, output_data, output_valid
  );
endinterface

// File: rtl/seg_disp_arbiter.sv
// Round-robin display-datapath arbiter with minimum hold; all outputs registered, 1-cycle request-to-grant, no backpressure.
// Optional SEG_DISP_ARB_PRIO_EN: requester 0 preempts any owner and is never timed out by hold expiry.
module seg_disp_arbiter #(
  parameter  int N_REQ       = 4,
  parameter  int HOLD_CYCLES = 1000,
  localparam int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  seg_disp_arbiter_if.slave bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic              busy_q, busy_d;
  logic              switch_pulse_q, switch_pulse_d;
  logic [31:0]       output_data_q, output_data_d;
  logic [7:0]        output_valid_q, output_valid_d;

  logic [31:0]       slice_data  [N_REQ];
  logic [7:0]        slice_valid [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
    assign slice_data[gi]  = bus.req_data[32*gi +: 32];
    assign slice_valid[gi] = bus.req_valid[8*gi +: 8];
  end

  // owner_q doubles as last_owner: it keeps its value through IDLE so the search resumes after it.
  logic [IDX_W-1:0]  rr_win;
  logic [IDX_W-1:0]  rr_idx;
  logic              rr_found;

  always_comb begin
    rr_win   = owner_q;
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      rr_idx = IDX_W'((int'(owner_q) + i) % N_REQ);
      if (!rr_found && bus.req[rr_idx]) begin
        rr_found = 1'b1;
        rr_win   = rr_idx;
      end
    end
  end

  logic              other_pend;
  logic [IDX_W-1:0]  win;
  logic              prio_take;
  logic              hold_lock;

  assign other_pend = |(bus.req & ~grant_q);

`ifdef SEG_DISP_ARB_PRIO_EN
  assign win       = bus.req[0] ? '0 : rr_win;
  assign prio_take = bus.req[0] && (owner_q != '0);
  assign hold_lock = (owner_q == '0);
`else
  assign win       = rr_win;
  assign prio_take = 1'b0;
  assign hold_lock = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    hold_cnt_d     = hold_cnt_q;
    switch_pulse_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d    = GRANT;
          owner_d    = win;
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        // A released owner is checked first so a drop coinciding with hold expiry never idles needlessly.
        if (!bus.req[owner_q]) begin
          hold_cnt_d = '0;
          if (other_pend) begin
            owner_d        = win;
            switch_pulse_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (prio_take || (hold_cnt_q == HOLD_MAX && other_pend && !hold_lock)) begin
          owner_d        = win;
          hold_cnt_d     = '0;
          switch_pulse_d = 1'b1;
        end else if (hold_cnt_q != HOLD_MAX) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        hold_cnt_d = '0;
      end
    endcase

    // Data follows owner_d so grant and display data switch on the same edge.
    grant_d        = '0;
    busy_d         = (state_d == GRANT);
    output_data_d  = 32'h0;
    output_valid_d = 8'h01;
    if (state_d == GRANT) begin
      grant_d[owner_d] = 1'b1;
      output_data_d    = slice_data[owner_d];
      output_valid_d   = slice_valid[owner_d] | 8'h01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      owner_q        <= LAST_IDX;
      hold_cnt_q     <= '0;
      grant_q        <= '0;
      busy_q         <= 1'b0;
      switch_pulse_q <= 1'b0;
      output_data_q  <= 32'h0;
      output_valid_q <= 8'h01;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      hold_cnt_q     <= hold_cnt_d;
      grant_q        <= grant_d;
      busy_q         <= busy_d;
      switch_pulse_q <= switch_pulse_d;
      output_data_q  <= output_data_d;
      output_valid_q <= output_valid_d;
    end
  end

  assign bus.grant        = grant_q;
  assign bus.busy         = busy_q;
  assign bus.switch_pulse = switch_pulse_q;
  assign bus.output_data  = output_data_q;
  assign bus.output_valid = output_valid_q;

  a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));
  a_busy_matches  : assert property (@(posedge clk) disable iff (!rst_n) busy_q == |grant_q);
  a_valid_bit0    : assert property (@(posedge clk) disable iff (!rst_n) output_valid_q[0]);

endmodule

// File: doc/seg_disp_arbiter.md
Name: seg_disp_arbiter

Overview:
Shares the 8-digit seven-segment display datapath between N_REQ requesters, e.g. a counter, a key-entry unit and a debug readout. It arbitrates round-robin with a guaranteed minimum hold time so each shown value stays readable. It drives the `output_data`/`output_valid` pair that feeds the `Segment` scanner.

Parameters:
N_REQ, 4, number of requesters (2..8).
HOLD_CYCLES, 1000, minimum grant duration in clk cycles before another pending requester may take over (>=1).
CNT_W, $clog2(HOLD_CYCLES+1), width of the hold counter (derived, not overridden).

Ports:
clk  input  1  system clock, all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
req  input  N_REQ  per-requester display request, level-held while the requester wants the display.
req_data  input  32*N_REQ  requester i hex digits in bits [32i+31:32i]; nibble k = digit k.
req_valid  input  8*N_REQ  requester i digit enables in bits [8i+7:8i].
grant  output  N_REQ  one-hot current owner; all-zero when idle; registered.
busy  output  1  high when any grant is active; registered.
switch_pulse  output  1  one-cycle pulse on the cycle grant changes between two nonzero owners.
output_data  output  32  to `Segment`.output_data; registered.
output_valid  output  8  to `Segment`.output_valid; registered; bit 0 always 1.

Behaviour:
- Reset (async, rst_n=0), all outputs and state:
  - grant=0, busy=0, switch_pulse=0.
  - output_data=32'h0, output_valid=8'h01.
  - state=IDLE, hold_cnt=0, last_owner=N_REQ-1, so the first search starts at requester 0.
- rst_n deassertion mid-operation: next state is always IDLE; there is no memory of the prior owner.
- Round-robin search: scan indices last_owner+1 … last_owner+N_REQ (mod N_REQ) and pick the first with req=1. The current owner is therefore chosen only if no other requester is pending.
- IDLE:
  - If any req=1: grant the search winner at the next edge, set hold_cnt=0, go to GRANT. switch_pulse stays 0.
  - Else remain; grant=0.
- GRANT, owner o, evaluated each edge in this priority:
  1. req[o]=0:
     - Another requester pending: hand over directly to the search winner (no idle cycle), hold_cnt=0, switch_pulse=1.
     - None pending: go to IDLE, grant=0, output_data=0, output_valid=8'h01.
  2. hold_cnt==HOLD_CYCLES-1 and another req pending: hand over to the search winner, hold_cnt=0, switch_pulse=1.
  3. Otherwise: stay. hold_cnt increments and saturates at HOLD_CYCLES-1.
- last_owner updates to the new owner on every grant.
- Output path:
  - Each edge while in GRANT or entering GRANT: output_data <= req_data slice of the new/current owner; output_valid <= its req_valid slice OR 8'h01.
  - output_data/output_valid change on the same edge that grant changes, so there is no cycle of mixed-owner data.
  - Owner data is tracked live, not latched at grant.
- Simultaneous events:
  - Owner drop and hold expiry in the same cycle: rule 1 applies.
  - Multiple new requests: the round-robin order decides.
- Invariants:
  - grant is never multi-hot.
  - busy==|grant.
  - switch_pulse is never high on IDLE->GRANT or GRANT->IDLE.
- HOLD_CYCLES=1: handover is possible every cycle when contended.

Optional Feature:
- Macro: SEG_DISP_ARB_PRIO_EN.
- Defined:
  - Requester 0 is high priority. If req[0]=1 and owner!=0, grant moves to 0 at the next edge regardless of hold_cnt, with switch_pulse=1.
  - While owner=0, hold expiry never hands over; only req[0]=0 releases.
  - Round-robin among 1..N_REQ-1 is unchanged.
- Not defined: pure round-robin as described; requester 0 has no special treatment.

Test Plan:
- Setup for all scenarios: N_REQ=4, HOLD_CYCLES=4.
- Reset then idle: rst_n=0 then 1, req=0 -> grant=0, output_data=0, output_valid=8'h01, busy=0 for 10 cycles.
- Single request: req=4'b0100, req_data slice2=32'h1234_5678, req_valid slice2=8'h0F -> next edge grant=4'b0100, output_data=32'h12345678, output_valid=8'h0F, switch_pulse=0.
- Contention and hold:
  - Stimulus: req=4'b0011 from IDLE.
  - Grant sequence: grant=0001 for exactly 4 cycles, then 0010 with a 1-cycle switch_pulse, then 0001 after 4 more cycles.
- Early release: owner 1 drops req at hold_cnt=1 while req[3]=1 -> next edge grant=4'b1000, switch_pulse=1, output tracks slice3.
- Async reset mid-grant: pull rst_n low between edges while grant=0010 -> outputs return to reset values immediately, without waiting for a clock edge. After release with req=4'b0010, grant=0010 again after 1 edge.
- SEG_DISP_ARB_PRIO_EN defined: owner 2 at hold_cnt=0, then raise req[0] -> next edge grant=0001. Hold req[0]=1 and req[2]=1 for 20 cycles -> grant stays 0001.
